// File: rtl/dm_store_ctrl.sv
// dm_store_ctrl: store-side controller for the word-organised data memory.
// Word stores are written directly. Byte and halfword stores read the
// target word, merge the new lane and write the whole word back, because
// the array has no byte enables.
module dm_store_ctrl #(
    parameter int AW    = 7,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [AW+1:0]    req_addr,
    input  logic [31:0]      req_data,
    input  logic [1:0]       STORESel,
    output logic [AW-1:0]    mem_addr,
    input  logic [31:0]      mem_rdata,
    output logic             mem_we,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             st_done,
    output logic             st_err,
    output logic [CNT_W-1:0] st_count
);

    localparam logic [1:0] SEL_SW = 2'b00;
    localparam logic [1:0] SEL_SB = 2'b01;
    localparam logic [1:0] SEL_SH = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              handshake;
    logic              aligned;
    logic [AW-1:0]     addr_q;
    logic [1:0]        off_q;
    logic [1:0]        sel_q;
    logic [31:0]       word_q;
    logic [31:0]       merged;
    logic              done_q;
    logic              err_q;
    logic [CNT_W-1:0]  count_q;

    assign req_ready = (state == IDLE);
    assign handshake = req_valid && req_ready;
    assign busy      = (state != IDLE);
    assign mem_we    = (state == WRITE);
    assign mem_wdata = mem_we ? word_q : 32'h0;
    assign mem_addr  = addr_q;
    assign st_done   = done_q;
    assign st_err    = err_q;
    assign st_count  = count_q;

    // Decide whether the presented request has a legal size/offset pairing.
    always_comb begin
        aligned = 1'b0;
        unique case (STORESel)
            SEL_SW:  aligned = (req_addr[1:0] == 2'b00);
            SEL_SB:  aligned = 1'b1;
            SEL_SH:  aligned = !req_addr[0];
            default: aligned = 1'b0;
        endcase
    end

    // State register; an asynchronous reset abandons any store in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: word stores skip the read, sub-word stores read first.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (handshake && aligned) begin
                    state_next = (STORESel == SEL_SW) ? WRITE : READ;
                end
            end
            READ:    state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Merge the latched byte or halfword into the word currently read back.
    always_comb begin
        merged = mem_rdata;
        if (sel_q == SEL_SB) begin
            unique case (off_q)
                2'b00:   merged[7:0]   = word_q[7:0];
                2'b01:   merged[15:8]  = word_q[7:0];
                2'b10:   merged[23:16] = word_q[7:0];
                default: merged[31:24] = word_q[7:0];
            endcase
        end else if (sel_q == SEL_SH) begin
            if (off_q[1]) begin
                merged[31:16] = word_q[15:0];
            end else begin
                merged[15:0] = word_q[15:0];
            end
        end
    end

    // Request latch, merge capture, status pulses and the completed-store counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q  <= '0;
            off_q   <= '0;
            sel_q   <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            done_q <= (state == WRITE);
            err_q  <= handshake && !aligned;
            if (state == WRITE) begin
                count_q <= count_q + CNT_W'(1);
            end
            if (handshake && aligned) begin
                addr_q <= req_addr[AW+1:2];
                off_q  <= req_addr[1:0];
                sel_q  <= STORESel;
                word_q <= req_data;
            end else if (state == READ) begin
                word_q <= merged;
            end
        end
    end

endmodule

// File: doc/dm_store_ctrl.md
Name: dm_store_ctrl

Overview:
- Store-side controller for the word-organised data memory: takes one sw/sb/sh request per handshake and turns it into a whole-word write.
- The memory array has no byte enables, so sub-word stores are done as read-modify-write: read the word, merge the new byte or halfword, write it back.
- Sits between the execute-stage store path and the data-memory array. It is the write-direction counterpart of the load-extraction logic.
- Asserts busy so the pipeline holds loads and stores while a store is in flight.

Parameters:
AW, 7, word-address width; byte address width is AW+2.
CNT_W, 16, width of the completed-store counter.

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
req_valid  in  1  store request present
req_ready  out  1  controller can accept a request
req_addr  in  AW+2  byte address of the store
req_data  in  32  store data; byte/halfword taken from bits [7:0]/[15:0]
STORESel  in  2  00=sw, 01=sb, 10=sh, 11=reserved
mem_addr  out  AW  word address to the memory array
mem_rdata  in  32  combinational read data of word mem_addr
mem_we  out  1  write strobe; memory writes on the rising clk edge
mem_wdata  out  32  merged write word
busy  out  1  store in progress (state != IDLE)
st_done  out  1  one-cycle pulse, the cycle after the write edge
st_err  out  1  one-cycle pulse on a rejected request
st_count  out  CNT_W  completed stores, wraps to 0

Behaviour:
- Reset (async, rstn=0) forces:
  - state IDLE; req_ready=1.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - busy=0, st_done=0, st_err=0, st_count=0.
  - Latched request registers cleared.
- Reset mid-operation abandons the store: no write occurs, and mem_we drops immediately.
- States: IDLE, READ, WRITE. Handshake fires on req_valid && req_ready; req_ready=1 only in IDLE.
- IDLE, on handshake:
  - Latch word address (req_addr[AW+1:2]), byte offset (req_addr[1:0]), req_data and STORESel.
  - sw with offset 00 -> WRITE.
  - sb (any offset), or sh with offset 00 or 10 -> READ.
  - Misaligned requests are rejected: sh with offset[0]=1, sw with offset!=00, or STORESel=11. A rejected request stays in IDLE, pulses st_err next cycle, performs no memory access, and does not change st_count.
- READ (one cycle):
  - mem_addr = latched word address.
  - mem_rdata sampled at the clock edge and merged:
    - sb writes the byte lane selected by offset (00->[7:0], 01->[15:8], 10->[23:16], 11->[31:24]).
    - sh writes [15:0] for offset 00, [31:16] for offset 10.
    - All other bits are taken unchanged from mem_rdata.
  - Next state WRITE.
- WRITE (one cycle):
  - mem_we=1, mem_addr = latched address.
  - mem_wdata = merged word (sw: latched data unmodified).
  - Next state IDLE; st_done pulses in the following cycle; st_count increments by 1, modulo 2^CNT_W.
- mem_we and mem_wdata are driven combinationally from state and registers. mem_we is 0 outside WRITE. mem_addr holds its last value in IDLE.
- Latency, counting from the handshake edge N:
  - sw writes at edge N+1; st_done high in cycle N+1..N+2.
  - sb/sh read in cycle N..N+1, write at edge N+2.
- A request presented while busy is not accepted; the requester must hold req_valid and its fields stable until req_ready.
- A new handshake can occur in the cycle after WRITE, i.e. back-to-back sw at one store per 2 cycles.
- Simultaneous st_done and a new handshake are allowed.
- st_count wraps from 2^CNT_W-1 to 0 without a flag.

Test Plan:
- Reset then sw: rstn low 3 cycles, release; sw addr=0x010, data=0xDEADBEEF -> mem_we high exactly one cycle with mem_addr=4, mem_wdata=0xDEADBEEF; st_count=1.
- sb per lane: word 5 preloaded 0x11223344; sb addr=0x016 (offset 10), data=0x000000AB -> mem_wdata=0x11AB3344 at edge N+2; busy high 2 cycles.
- sh upper/lower: word 2 = 0xAAAABBBB; sh addr=0x00A, data=0x1234 -> 0x1234BBBB; then sh addr=0x008, data=0x5678 -> 0x12345678.
- Misaligned: sh addr=0x003 and sw addr=0x006 -> st_err pulse each, mem_we never asserted, st_count unchanged, req_ready stays 1.
- Backpressure and reset: sb accepted, second request held valid during READ -> req_ready=0 until IDLE, then second accepted. Separately, rstn low during READ -> no write occurs and all outputs return to reset values.
- Counter wrap with CNT_W=2: 5 sw stores -> st_count sequence 1,2,3,0,1.
